// File: rtl/uv_top_line_buffer_if.sv
// Handshake/data bundle between the UV intra predictors and the top-context line buffer.
// master = predictor side, slave = line buffer.
interface uv_top_line_buffer_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int MB_CNT_W   = 7
);
  logic                            start;
  logic [MB_CNT_W-1:0]             mb_w;
  logic [MB_CNT_W-1:0]             mb_h;
  logic                            rd_req;
  logic                            rd_ready;
  logic                            rd_valid;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] top_u;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] top_v;
  logic                            top_avail;
  logic                            wr_valid;
  logic                            wr_ready;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] wr_u;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] wr_v;
  logic                            busy;
  logic                            frame_done;
  logic                            par_err;

  modport master (
    output start, mb_w, mb_h, rd_req, wr_valid, wr_u, wr_v,
    input  rd_ready, rd_valid, top_u, top_v, top_avail, wr_ready, busy, frame_done, par_err
  );

  modport slave (
    input  start, mb_w, mb_h, rd_req, wr_valid, wr_u, wr_v,
    output rd_ready, rd_valid, top_u, top_v, top_avail, wr_ready, busy, frame_done, par_err
  );
endinterface

// File: rtl/uv_top_line_buffer.sv
// Chroma top-context line buffer: one {V,U} bottom row per MB column, read back one MB row later.
// Define UV_LB_PARITY_EN to store and check one even-parity bit per byte (sticky par_err).
module uv_top_line_buffer #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int MAX_MB_W   = 64,
  parameter int MB_CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uv_top_line_buffer_if.slave  lb
);
  localparam int ROW_W  = BIT_WIDTH * BLOCK_SIZE;
  localparam int ADDR_W = (MAX_MB_W > 1) ? $clog2(MAX_MB_W) : 1;
  localparam int NBYTES = 2 * BLOCK_SIZE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  localparam logic [BIT_WIDTH-1:0] PIX_MID = BIT_WIDTH'(127);
  localparam logic [MB_CNT_W-1:0]  W_MAX   = MB_CNT_W'(MAX_MB_W);
  localparam logic [MB_CNT_W-1:0]  ONE     = MB_CNT_W'(1);

  logic [1:0]          state;
  logic [MB_CNT_W-1:0] mb_x, mb_y, w_lat, h_lat;
  logic [MB_CNT_W-1:0] w_clamped;
  logic [2*ROW_W-1:0]  mem [MAX_MB_W];
  logic [2*ROW_W-1:0]  wr_word, rd_word;
  logic [ADDR_W-1:0]   addr;
  logic                rd_fire, wr_fire, last_col, last_mb;
  logic                rd_valid_q, frame_done_q, top_avail_q, par_err_q;
  logic [ROW_W-1:0]    top_u_q, top_v_q;

  assign addr      = mb_x[ADDR_W-1:0];
  assign wr_word   = {lb.wr_v, lb.wr_u};
  assign rd_word   = mem[addr];
  assign rd_fire   = (state == S_RD) && lb.rd_req;
  assign wr_fire   = (state == S_WR) && lb.wr_valid;
  assign last_col  = (mb_x == w_lat - ONE);
  assign last_mb   = last_col && (mb_y == h_lat - ONE);
  assign w_clamped = (lb.mb_w > W_MAX) ? W_MAX : lb.mb_w;

  assign lb.rd_ready   = (state == S_RD);
  assign lb.wr_ready   = (state == S_WR);
  assign lb.busy       = (state != S_IDLE);
  assign lb.rd_valid   = rd_valid_q;
  assign lb.frame_done = frame_done_q;
  assign lb.top_u      = top_u_q;
  assign lb.top_v      = top_v_q;
  assign lb.top_avail  = top_avail_q;
  assign lb.par_err    = par_err_q;

  // Strict RD -> WR alternation per MB means column x is always read before it is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mb_x         <= '0;
      mb_y         <= '0;
      w_lat        <= '0;
      h_lat        <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      top_avail_q  <= 1'b0;
      top_u_q      <= '0;
      top_v_q      <= '0;
    end else begin
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lb.start && (lb.mb_w != '0) && (lb.mb_h != '0)) begin
            w_lat <= w_clamped;
            h_lat <= lb.mb_h;
            mb_x  <= '0;
            mb_y  <= '0;
            state <= S_RD;
          end
        end
        S_RD: begin
          if (lb.rd_req) begin
            rd_valid_q <= 1'b1;
            state      <= S_WR;
            if (mb_y == '0) begin
              top_u_q     <= {BLOCK_SIZE{PIX_MID}};
              top_v_q     <= {BLOCK_SIZE{PIX_MID}};
              top_avail_q <= 1'b0;
            end else begin
              top_u_q     <= rd_word[ROW_W-1:0];
              top_v_q     <= rd_word[2*ROW_W-1:ROW_W];
              top_avail_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (lb.wr_valid) begin
            if (last_col) begin
              mb_x <= '0;
              mb_y <= mb_y + ONE;
            end else begin
              mb_x <= mb_x + ONE;
            end
            if (last_mb) begin
              frame_done_q <= 1'b1;
              state        <= S_IDLE;
            end else begin
              state <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is intentionally not reset; row 0 substitutes the synthetic top instead of reading it.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[addr] <= wr_word;
  end

`ifdef UV_LB_PARITY_EN
  logic [NBYTES-1:0] par_mem [MAX_MB_W];
  logic [NBYTES-1:0] wr_par, rd_par;

  always_comb begin
    wr_par = '0;
    rd_par = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wr_par[i] = ^wr_word[i*BIT_WIDTH +: BIT_WIDTH];
      rd_par[i] = ^rd_word[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) par_mem[addr] <= wr_par;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (rd_fire && (mb_y != '0) && (rd_par != par_mem[addr])) begin
      par_err_q <= 1'b1;
    end
  end
`else
  assign par_err_q = 1'b0;
`endif

endmodule

// File: tb/tb_uv_top_line_buffer.sv
// Self-checking bench for uv_top_line_buffer: random frames against a per-column array model.
// Build with UV_LB_PARITY_EN defined to exercise the parity fault path.
module tb_uv_top_line_buffer;
  localparam int BW   = 8;
  localparam int BS   = 8;
  localparam int MAXW = 64;
  localparam int CW   = 7;
  localparam int ROW  = BW * BS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uv_top_line_buffer_if #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .MB_CNT_W(CW)) lb ();

  uv_top_line_buffer #(
    .BIT_WIDTH(BW), .BLOCK_SIZE(BS), .MAX_MB_W(MAXW), .MB_CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lb   (lb)
  );

  // Model: last bottom row written to each column, plus the expected sticky parity flag.
  logic [ROW-1:0] model_u [MAXW];
  logic [ROW-1:0] model_v [MAXW];
  logic           exp_par;
  int             tests = 0;
  int             fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if (lb.rd_ready !== 1'b0 || lb.rd_valid !== 1'b0 || lb.wr_ready !== 1'b0 ||
        lb.top_u !== '0 || lb.top_v !== '0 || lb.top_avail !== 1'b0 ||
        lb.busy !== 1'b0 || lb.frame_done !== 1'b0 || lb.par_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s: rd_ready=%b rd_valid=%b wr_ready=%b top_u=%h top_v=%h avail=%b busy=%b done=%b par=%b, required all 0",
               tag, lb.rd_ready, lb.rd_valid, lb.wr_ready, lb.top_u, lb.top_v, lb.top_avail,
               lb.busy, lb.frame_done, lb.par_err);
    end
  endtask

  // mode: 0 random data, 1 column pattern, 2 handshake abuse, 3 start pulses while busy
  task automatic run_frame(input int w, input int h, input int mode, input int inject_x);
    int             ew;
    bit             ok;
    bit             last;
    int             dly;
    logic [ROW-1:0] eu, ev, du, dv;
    logic           ea;
    ew = (w > MAXW) ? MAXW : w;
    lb.mb_w  = CW'(w);
    lb.mb_h  = CW'(h);
    lb.start = 1'b1;
    tick();
    lb.start = 1'b0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < ew; x++) begin
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
          if (lb.rd_ready === 1'b1) ok = 1'b1;
          else tick();
        end
        tests++;
        if (!ok) begin
          fails++;
          $display("[TB] FAIL rd_ready_timeout: x=%0d y=%0d rd_ready=%b, required 1", x, y, lb.rd_ready);
          return;
        end

        if (mode == 2) begin
          lb.wr_valid = 1'b1;
          lb.wr_u = {$urandom(), $urandom()};
          lb.wr_v = {$urandom(), $urandom()};
          tick();
          tick();
          lb.wr_valid = 1'b0;
          tests++;
          if (lb.rd_ready !== 1'b1 || lb.wr_ready !== 1'b0 || lb.rd_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wr_in_rd_ignored: rd_ready=%b wr_ready=%b rd_valid=%b, required 1 0 0",
                     lb.rd_ready, lb.wr_ready, lb.rd_valid);
          end
        end

        if (mode == 3) begin
          lb.mb_w  = CW'(5);
          lb.mb_h  = CW'(5);
          lb.start = 1'b1;
          tick();
          lb.start = 1'b0;
          lb.mb_w  = CW'(w);
          lb.mb_h  = CW'(h);
          tests++;
          if (lb.rd_ready !== 1'b1 || lb.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL start_while_busy: rd_ready=%b busy=%b, required 1 1", lb.rd_ready, lb.busy);
          end
        end

`ifdef UV_LB_PARITY_EN
        if (y == 1 && x == inject_x) begin
          dut.mem[x][3] = ~dut.mem[x][3];
          model_u[x][3] = ~model_u[x][3];
          exp_par = 1'b1;
        end
`endif

        lb.rd_req = 1'b1;
        tick();
        if (mode != 2) lb.rd_req = 1'b0;
        eu = (y == 0) ? {BS{8'h7F}} : model_u[x];
        ev = (y == 0) ? {BS{8'h7F}} : model_v[x];
        ea = (y != 0);
        tests++;
        if (lb.rd_valid !== 1'b1 || lb.top_u !== eu || lb.top_v !== ev || lb.top_avail !== ea ||
            lb.wr_ready !== 1'b1 || lb.par_err !== exp_par) begin
          fails++;
          $display("[TB] FAIL read x=%0d y=%0d: rd_valid=%b top_u=%h top_v=%h avail=%b wr_ready=%b par=%b, required 1 %h %h %b 1 %b",
                   x, y, lb.rd_valid, lb.top_u, lb.top_v, lb.top_avail, lb.wr_ready, lb.par_err,
                   eu, ev, ea, exp_par);
        end

        dly = (mode == 2) ? 2 : $urandom_range(0, 2);
        for (int d = 0; d < dly; d++) begin
          tick();
          tests++;
          if (lb.rd_valid !== 1'b0 || lb.top_u !== eu || lb.top_v !== ev || lb.wr_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL hold_in_wr x=%0d y=%0d: rd_valid=%b top_u=%h top_v=%h wr_ready=%b, required 0 %h %h 1",
                     x, y, lb.rd_valid, lb.top_u, lb.top_v, lb.wr_ready, eu, ev);
          end
        end
        lb.rd_req = 1'b0;

        if (mode == 1) begin
          du = {BS{8'(x + 1)}};
          dv = ~du;
        end else begin
          du = {$urandom(), $urandom()};
          dv = {$urandom(), $urandom()};
        end
        lb.wr_u = du;
        lb.wr_v = dv;
        lb.wr_valid = 1'b1;
        tick();
        lb.wr_valid = 1'b0;
        model_u[x] = du;
        model_v[x] = dv;
        last = (y == h - 1) && (x == ew - 1);
        tests++;
        if (lb.frame_done !== last || lb.busy !== !last || lb.rd_ready !== !last) begin
          fails++;
          $display("[TB] FAIL after_write x=%0d y=%0d: frame_done=%b busy=%b rd_ready=%b, required %b %b %b",
                   x, y, lb.frame_done, lb.busy, lb.rd_ready, last, !last, !last);
        end
      end
    end
    tick();
    tests++;
    if (lb.frame_done !== 1'b0 || lb.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_done_pulse: frame_done=%b busy=%b, required 0 0", lb.frame_done, lb.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick();
    tick();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_row_readback();
    run_frame(4, 2, 1, -1);
  endtask

  task automatic test_order_handshake();
    run_frame(3, 3, 2, -1);
  endtask

  task automatic test_wrap_end();
    run_frame(1, 3, 3, -1);
    lb.mb_w = '0;
    lb.mb_h = CW'(3);
    lb.start = 1'b1;
    tick();
    lb.mb_w = CW'(3);
    lb.mb_h = '0;
    tick();
    lb.start = 1'b0;
    tests++;
    if (lb.busy !== 1'b0 || lb.rd_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_size_start: busy=%b rd_ready=%b, required 0 0", lb.busy, lb.rd_ready);
    end
  endtask

  task automatic test_clamp_random();
    run_frame(100, 2, 0, -1);
    for (int f = 0; f < 3; f++) begin
      run_frame($urandom_range(1, 10), $urandom_range(1, 3), 0, -1);
    end
  endtask

  task automatic test_parity();
    run_frame(3, 3, 0, 1);
  endtask

  task automatic test_reset_midframe();
    lb.mb_w = CW'(3);
    lb.mb_h = CW'(2);
    lb.start = 1'b1;
    tick();
    lb.start = 1'b0;
    lb.rd_req = 1'b1;
    tick();
    lb.rd_req = 1'b0;
    lb.wr_valid = 1'b1;
    lb.wr_u = '1;
    lb.wr_v = '1;
    rst_n = 1'b0;
    exp_par = 1'b0;
    #2;
    check_all_zero("reset_midframe");
    tick();
    lb.wr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tests++;
    if (lb.rd_ready !== 1'b0 || lb.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL need_start_after_reset: rd_ready=%b busy=%b, required 0 0", lb.rd_ready, lb.busy);
    end
    run_frame(2, 2, 0, -1);
  endtask

  initial begin
    lb.start    = 1'b0;
    lb.mb_w     = '0;
    lb.mb_h     = '0;
    lb.rd_req   = 1'b0;
    lb.wr_valid = 1'b0;
    lb.wr_u     = '0;
    lb.wr_v     = '0;
    exp_par     = 1'b0;
    test_reset();
    test_row_readback();
    test_order_handshake();
    test_wrap_end();
    test_clamp_random();
    test_parity();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
